wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 16x16 register file. Merges two result producers, the ALU and the data-memory load path, onto the register file's single write port (DstReg / DstData / WriteReg).
- Each producer has its own small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFO heads at one write per cycle.
- Exports a per-register pending-write vector so decode can stall on RAW hazards the register file's same-cycle bypass cannot cover.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, >=2)
- DW, 16, data width
- RW, 4, register-id width
- DROP_R0, 1, when 1 a write targeting register 0 is consumed but never drives WriteReg

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_reg  in  RW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load FIFO can accept
- mem_reg  in  RW  load destination register
- mem_data  in  DW  load data
- WriteReg  out  1  register-file write enable (registered)
- DstReg  out  RW  register-file write address (registered)
- DstData  out  DW  register-file write data (registered)
- pending  out  16  bit i = 1 while any write to register i is queued or held in the output register
- alu_count  out  log2(DEPTH)+1  ALU FIFO occupancy
- mem_count  out  log2(DEPTH)+1  load FIFO occupancy

Behaviour:
- Reset (rst low, async):
  - Both FIFOs empty; counts 0.
  - WriteReg=0, DstReg=0, DstData=0, pending=0.
  - last_grant=MEM, so the ALU wins the first tie.
- Enqueue:
  - An entry is accepted at a rising edge when x_valid & x_ready.
  - x_ready = (x_count < DEPTH). It is combinational from count only, never from valid.
  - When full, ready is 0 even if a dequeue happens the same cycle; there is no pass-through.
- Simultaneous enqueue and dequeue on one FIFO: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- Arbitration (combinational on FIFO heads):
  - Only one head non-empty: grant it.
  - Both non-empty: grant the source that was not last_grant.
  - last_grant updates only on a grant.
  - Neither non-empty: no grant.
- Output register, each edge:
  - With a grant: pop the granted head. DstReg and DstData load the head. WriteReg = ~(DROP_R0 & head_reg==0).
  - With no grant: WriteReg=0; DstReg and DstData hold their values.
- Latency:
  - Entry accepted at edge k into an empty FIFO with no contention: WriteReg=1 from edge k+1 to edge k+2. The register file writes at edge k+2.
  - Sustained throughput is 1 write per cycle total.
- pending:
  - OR of one-hot(reg) over all valid FIFO entries, plus one-hot(DstReg) when WriteReg=1.
  - Combinational from state. Entries with reg 0 are excluded when DROP_R0=1.
- Ordering:
  - Order within one source is strictly FIFO.
  - No ordering is enforced across sources. Producers must not issue a second write to register r while pending[r]=1. This is decode's stall responsibility.
  - A violation is flagged by a bench assertion, not handled in RTL.
- Reset mid-operation: all queued entries are discarded, no write is issued, and pending clears immediately (async).

Decomposition:
- Shared package `wb_pkg`: the DW/RW defaults, the source-id constants SRC_ALU=0 and SRC_MEM=1, and a wb_entry record (reg, data).
- One natural sub-module, `wb_fifo`: a parameterised sync FIFO with count, ready, head outputs and a per-entry valid/reg view for the pending vector. It is instantiated twice.
- The arbiter and output register stay in the top.

Test Plan:
- Reset, then alu push (r3, 0x1234) at edge 1 -> WriteReg=1, DstReg=3, DstData=0x1234 between edges 2 and 3; pending[3]=1 from edge 1 until edge 3.
- Alu (r1, 0xAAAA) and mem (r2, 0x5555) pushed the same edge -> ALU write first, mem write next cycle; repeat the pair -> mem wins the tie and ALU goes second (round-robin alternation).
- Hold mem_valid for 3 pushes with the ALU saturating arbitration -> mem_ready=0 once mem_count=2; the third push is accepted only after a drain; no data loss or reorder (compare against a scoreboard).
- Push (r0, 0xFFFF) with DROP_R0=1 -> entry consumed, WriteReg stays 0, pending stays 0.
- Fill both FIFOs (4 entries), assert rst low mid-cycle -> counts 0, WriteReg=0, pending=0 immediately; after release both ready=1.
- Random valid streams over 10k cycles with decode-style stalling on pending -> the register-file model matches the golden model and the one-write-per-cycle invariant holds.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: default widths, source ids and the
// queued-result record.
package wb_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RW_DEF = 4;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic [RW_DEF-1:0] rd;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous result FIFO with occupancy, ready and head outputs, plus a per-slot
// valid/register view used to build the pending-write vector.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned RW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [RW-1:0]              push_reg_i,
    input  logic [DW-1:0]              push_data_i,
    output logic                       ready_o,
    input  logic                       pop_i,
    output logic                       head_valid_o,
    output logic [RW-1:0]              head_reg_o,
    output logic [DW-1:0]              head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           ent_valid_o,
    output logic [DEPTH-1:0][RW-1:0]   ent_reg_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [RW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    // Ready depends on occupancy only: a full FIFO refuses even if it pops this cycle.
    assign ready_o      = count_q < CW'(DEPTH);
    assign head_valid_o = count_q != '0;
    assign push         = push_i & ready_o;
    assign pop          = pop_i & head_valid_o;
    assign head_reg_o   = reg_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= push_reg_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        logic [PW-1:0] offs;
        offs        = '0;
        ent_valid_o = '0;
        ent_reg_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PW'(i) - rd_ptr_q;
            ent_valid_o[i] = {1'b0, offs} < count_q;
            ent_reg_o[i]   = reg_q[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin merge of the ALU and load-result FIFOs onto the register
// file's single write port, with a pending-write vector for decode hazard stalls.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RW      = RW_DEF,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [RW-1:0]          alu_reg,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [RW-1:0]          mem_reg,
    input  logic [DW-1:0]          mem_data,
    output logic                   WriteReg,
    output logic [RW-1:0]          DstReg,
    output logic [DW-1:0]          DstData,
    output logic [2**RW-1:0]       pending,
    output logic [$clog2(DEPTH):0] alu_count,
    output logic [$clog2(DEPTH):0] mem_count
);

    logic                     alu_hv, mem_hv;
    logic [RW-1:0]            alu_hreg, mem_hreg;
    logic [DW-1:0]            alu_hdata, mem_hdata;
    logic [DEPTH-1:0]         alu_ev, mem_ev;
    logic [DEPTH-1:0][RW-1:0] alu_er, mem_er;

    logic          gnt_alu, gnt_mem, drop;
    logic [RW-1:0] sel_reg;
    logic [DW-1:0] sel_data;

    logic          write_q;
    logic [RW-1:0] dst_reg_q;
    logic [DW-1:0] dst_data_q;
    logic          last_grant_q;
    logic [2**RW-1:0] pend_vec;

    wb_fifo #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) u_alu_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (alu_valid),
        .push_reg_i   (alu_reg),
        .push_data_i  (alu_data),
        .ready_o      (alu_ready),
        .pop_i        (gnt_alu),
        .head_valid_o (alu_hv),
        .head_reg_o   (alu_hreg),
        .head_data_o  (alu_hdata),
        .count_o      (alu_count),
        .ent_valid_o  (alu_ev),
        .ent_reg_o    (alu_er)
    );

    wb_fifo #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) u_mem_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (mem_valid),
        .push_reg_i   (mem_reg),
        .push_data_i  (mem_data),
        .ready_o      (mem_ready),
        .pop_i        (gnt_mem),
        .head_valid_o (mem_hv),
        .head_reg_o   (mem_hreg),
        .head_data_o  (mem_hdata),
        .count_o      (mem_count),
        .ent_valid_o  (mem_ev),
        .ent_reg_o    (mem_er)
    );

    // On a tie the source that did not win last time gets the port.
    always_comb begin
        gnt_alu  = alu_hv & (~mem_hv | (last_grant_q == SRC_MEM));
        gnt_mem  = mem_hv & (~alu_hv | (last_grant_q == SRC_ALU));
        sel_reg  = gnt_mem ? mem_hreg : alu_hreg;
        sel_data = gnt_mem ? mem_hdata : alu_hdata;
        drop     = (DROP_R0 != 0) && (sel_reg == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q      <= 1'b0;
            dst_reg_q    <= '0;
            dst_data_q   <= '0;
            last_grant_q <= SRC_MEM;
        end else if (gnt_alu || gnt_mem) begin
            write_q      <= ~drop;
            dst_reg_q    <= sel_reg;
            dst_data_q   <= sel_data;
            last_grant_q <= gnt_mem ? SRC_MEM : SRC_ALU;
        end else begin
            write_q <= 1'b0;
        end
    end

    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ev[i] && !((DROP_R0 != 0) && (alu_er[i] == '0))) pend_vec[alu_er[i]] = 1'b1;
            if (mem_ev[i] && !((DROP_R0 != 0) && (mem_er[i] == '0))) pend_vec[mem_er[i]] = 1'b1;
        end
        if (write_q) pend_vec[dst_reg_q] = 1'b1;
    end

    assign WriteReg = write_q;
    assign DstReg   = dst_reg_q;
    assign DstData  = dst_data_q;
    assign pending  = pend_vec;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a cycle-level queue model
// scoreboard that predicts every write, count, ready and pending value.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned RW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic          alu_ready, mem_ready;
    logic [RW-1:0] alu_reg = '0, mem_reg = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          WriteReg;
    logic [RW-1:0] DstReg;
    logic [DW-1:0] DstData;
    logic [15:0]   pending;
    logic [1:0]    alu_count, mem_count;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .RW(RW), .DROP_R0(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .WriteReg  (WriteReg),
        .DstReg    (DstReg),
        .DstData   (DstData),
        .pending   (pending),
        .alu_count (alu_count),
        .mem_count (mem_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, round-robin state, output register and reg files.
    wb_entry_t     m_alu[$], m_mem[$];
    wb_entry_t     m_out, p_a, p_m;
    logic          m_last, m_wr, p_av, p_mv;
    logic [15:0]   pexp;
    logic [DW-1:0] rf_gold [16];
    logic [DW-1:0] rf_dut  [16];

    function automatic void model_reset();
        m_alu.delete();
        m_mem.delete();
        m_out  = '0;
        m_last = SRC_MEM;
        m_wr   = 1'b0;
        p_av   = 1'b0;
        p_mv   = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rf_gold[r] = '0;
            rf_dut[r]  = '0;
        end
    endfunction

    initial model_reset();
    always @(negedge rst) model_reset();

    always @(negedge clk) begin
        if (rst) begin
            logic ga, gm;
            // Advance the model across the rising edge that just happened.
            ga = (m_alu.size() > 0) && ((m_mem.size() == 0) || (m_last == SRC_MEM));
            gm = (m_mem.size() > 0) && !ga;
            if (ga) begin
                m_out  = m_alu.pop_front();
                m_last = SRC_ALU;
                m_wr   = (m_out.rd != 0);
            end else if (gm) begin
                m_out  = m_mem.pop_front();
                m_last = SRC_MEM;
                m_wr   = (m_out.rd != 0);
            end else begin
                m_wr = 1'b0;
            end
            if (p_av) begin
                m_alu.push_back(p_a);
                if (p_a.rd != 0) rf_gold[p_a.rd] = p_a.data;
            end
            if (p_mv) begin
                m_mem.push_back(p_m);
                if (p_m.rd != 0) rf_gold[p_m.rd] = p_m.data;
            end

            pexp = '0;
            foreach (m_alu[i]) if (m_alu[i].rd != 0) pexp[m_alu[i].rd] = 1'b1;
            foreach (m_mem[i]) if (m_mem[i].rd != 0) pexp[m_mem[i].rd] = 1'b1;
            if (m_wr) pexp[m_out.rd] = 1'b1;

            check_eq("sb_wr", WriteReg, m_wr);
            check_eq("sb_dst", {DstReg, DstData}, 32'(m_out));
            check_eq("sb_pending", pending, pexp);
            check_eq("sb_alu_count", alu_count, m_alu.size());
            check_eq("sb_mem_count", mem_count, m_mem.size());
            if (WriteReg) rf_dut[DstReg] = DstData;

            // Sample the offers that the next rising edge will see.
            check_eq("sb_alu_ready", alu_ready, m_alu.size() < DEPTH);
            check_eq("sb_mem_ready", mem_ready, m_mem.size() < DEPTH);
            p_av = alu_valid && (m_alu.size() < DEPTH);
            p_mv = mem_valid && (m_mem.size() < DEPTH);
            p_a  = '{rd: alu_reg, data: alu_data};
            p_m  = '{rd: mem_reg, data: mem_data};
            if (p_av && p_a.rd != 0) check_eq("hazard_alu", pexp[p_a.rd], 1'b0);
            if (p_mv && p_m.rd != 0) check_eq("hazard_mem", pexp[p_m.rd], 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    task automatic drive_alu(input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        alu_valid = v;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic drive_mem(input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        mem_valid = v;
        mem_reg   = r;
        mem_data  = d;
    endtask

    initial begin
        logic [RW-1:0] ra, rm;
        logic          av, mv;

        // Reset state
        #2;
        check_eq("rst_wr", WriteReg, 1'b0);
        check_eq("rst_dst", {DstReg, DstData}, 32'h0);
        check_eq("rst_pending", pending, 16'h0);
        check_eq("rst_counts", {alu_count, mem_count}, 4'h0);
        check_eq("rst_ready", {alu_ready, mem_ready}, 2'b11);
        #20 rst = 1'b1;

        // Single ALU write: latency and pending window
        tick();
        drive_alu(1'b1, 4'd3, 16'h1234);
        tick();
        alu_valid = 1'b0;
        check_eq("t1_wr_e1", WriteReg, 1'b0);
        check_eq("t1_pend_e1", pending, 16'h0008);
        tick();
        check_eq("t1_wr_e2", WriteReg, 1'b1);
        check_eq("t1_dst_e2", {DstReg, DstData}, {4'd3, 16'h1234});
        check_eq("t1_pend_e2", pending, 16'h0008);
        tick();
        check_eq("t1_wr_e3", WriteReg, 1'b0);
        check_eq("t1_pend_e3", pending, 16'h0000);

        // Round-robin alternation on back-to-back ties
        do_reset();
        drive_alu(1'b1, 4'd1, 16'hAAAA);
        drive_mem(1'b1, 4'd2, 16'h5555);
        tick();
        drive_alu(1'b1, 4'd4, 16'h4444);
        drive_mem(1'b1, 4'd5, 16'h5A5A);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check_eq("rr_w1", {WriteReg, DstReg, DstData}, {1'b1, 4'd1, 16'hAAAA});
        tick();
        check_eq("rr_w2", {WriteReg, DstReg, DstData}, {1'b1, 4'd2, 16'h5555});
        tick();
        check_eq("rr_w3", {WriteReg, DstReg, DstData}, {1'b1, 4'd4, 16'h4444});
        tick();
        check_eq("rr_w4", {WriteReg, DstReg, DstData}, {1'b1, 4'd5, 16'h5A5A});
        tick();
        check_eq("rr_idle", WriteReg, 1'b0);

        // Load FIFO back-pressure while the ALU keeps contending
        do_reset();
        drive_alu(1'b1, 4'd8, 16'h0800);
        drive_mem(1'b1, 4'd1, 16'h0100);
        tick();
        drive_alu(1'b1, 4'd9, 16'h0900);
        drive_mem(1'b1, 4'd2, 16'h0200);
        tick();
        check_eq("bp_mcount_full", mem_count, 2'd2);
        check_eq("bp_mready_full", mem_ready, 1'b0);
        check_eq("bp_first_wr", {WriteReg, DstReg}, {1'b1, 4'd8});
        drive_alu(1'b1, 4'd10, 16'h0A00);
        drive_mem(1'b1, 4'd3, 16'h0300);
        tick();
        check_eq("bp_mready_drain", mem_ready, 1'b1);
        check_eq("bp_mcount_drain", mem_count, 2'd1);
        check_eq("bp_mem_wr", {WriteReg, DstReg, DstData}, {1'b1, 4'd1, 16'h0100});
        alu_valid = 1'b0;
        tick();
        check_eq("bp_third_acc", mem_count, 2'd2);
        mem_valid = 1'b0;
        repeat (8) tick();
        check_eq("bp_drained", {alu_count, mem_count}, 4'h0);

        // Register 0 writes are consumed silently
        do_reset();
        drive_alu(1'b1, 4'd0, 16'hFFFF);
        tick();
        alu_valid = 1'b0;
        check_eq("r0_count", alu_count, 2'd1);
        check_eq("r0_pend_q", pending, 16'h0);
        tick();
        check_eq("r0_wr", WriteReg, 1'b0);
        check_eq("r0_pend_o", pending, 16'h0);
        check_eq("r0_popped", alu_count, 2'd0);
        tick();
        check_eq("r0_wr2", WriteReg, 1'b0);

        // Asynchronous reset with both FIFOs loaded
        do_reset();
        drive_alu(1'b1, 4'd1, 16'h0101);
        drive_mem(1'b1, 4'd2, 16'h0202);
        tick();
        drive_alu(1'b1, 4'd3, 16'h0303);
        drive_mem(1'b1, 4'd4, 16'h0404);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check_eq("ar_loaded", {alu_count, mem_count, WriteReg}, {2'd1, 2'd2, 1'b1});
        rst = 1'b0;
        #1;
        check_eq("ar_counts", {alu_count, mem_count}, 4'h0);
        check_eq("ar_wr", WriteReg, 1'b0);
        check_eq("ar_pending", pending, 16'h0);
        check_eq("ar_dst", {DstReg, DstData}, 32'h0);
        #2 rst = 1'b1;
        tick();
        check_eq("ar_ready", {alu_ready, mem_ready}, 2'b11);
        check_eq("ar_wr_after", WriteReg, 1'b0);

        // Random streams with decode-style stalling on pending
        for (int cyc = 0; cyc < 10000; cyc++) begin
            ra = RW'($urandom_range(0, 15));
            rm = RW'($urandom_range(0, 15));
            av = ($urandom_range(0, 3) != 0) && !pending[ra];
            mv = ($urandom_range(0, 3) != 0) && !pending[rm] && !(av && ra == rm);
            drive_alu(av, ra, DW'($urandom));
            drive_mem(mv, rm, DW'($urandom));
            tick();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (10) tick();
        for (int r = 0; r < 16; r++) check_eq($sformatf("rf_r%0d", r), rf_dut[r], rf_gold[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
